instruction_fetch_unit: RTL and testbench

Fetch stage for the LEGv8 datapath. Owns the fetch PC and issues one instruction-memory request at a time. Buffers returned instructions with their PCs in a small prefetch queue feeding decode (control unit, register bank, sign extend). Accepts branch redirects from the execute stage (branch & zero target), which flush the queue and any in-flight fetch.

---
 rtl/instruction_fetch_unit_pkg.sv | 13 +
 rtl/instruction_fetch_unit_if.sv | 35 +++
 rtl/instruction_fetch_unit_fetch_queue.sv | 58 +++++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } ifu_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory port, branch redirect and decode-side queue head.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  // The fetch unit is the master; memory, execute and decode sit on the slave side.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} pairs; synchronous flush, head masked to zero when empty.
module fetch_queue #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // NOTE: storage is not reset; r_count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: one outstanding imem request, prefetch queue toward decode, branch redirect flush.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int               ADDR_W   = 64,
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  ifu_state_t                r_state;
  ifu_state_t                w_state_next;
  logic [ADDR_W-1:0]         r_fetch_pc;
  logic [ADDR_W-1:0]         w_fetch_pc_next;
  logic [ADDR_W-1:0]         r_req_pc;
  logic [ADDR_W-1:0]         w_req_pc_next;
  logic [ADDR_W-1:0]         w_seq_pc;
  logic [ADDR_W-1:0]         w_redirect_pc;
  logic [CNT_W-1:0]          w_count;
  logic [CNT_W-1:0]          w_count_next;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_ack;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_flush;
  logic [ADDR_W+INSTR_W-1:0] w_head;

  assign w_ack         = bus.imem_ack && (r_state != IDLE);
  assign w_flush       = bus.redirect_valid;
  assign w_push        = (r_state == WAIT) && w_ack && !w_flush;
  assign w_pop         = !w_empty && bus.out_ready;
  assign w_count_next  = w_flush ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));
  assign w_seq_pc      = r_req_pc + PC_STEP;
  assign w_redirect_pc = bus.redirect_pc & ~ADDR_W'(3);

  fetch_queue #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({r_req_pc, bus.imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_pc   <= w_req_pc_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_pc_next   = r_req_pc;
    if (w_flush) begin
      // An unanswered request keeps its address on the bus; only its data is dropped later.
      w_fetch_pc_next = w_redirect_pc;
      w_state_next    = ((r_state != IDLE) && !w_ack) ? DISCARD : IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!w_full) begin
            w_state_next  = WAIT;
            w_req_pc_next = r_fetch_pc;
          end
        end
        WAIT: begin
          if (w_ack) begin
            w_fetch_pc_next = w_seq_pc;
            if (w_count_next < CNT_W'(DEPTH)) begin
              w_state_next  = WAIT;
              w_req_pc_next = w_seq_pc;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
        DISCARD: begin
          if (w_ack) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign bus.imem_req  = (r_state != IDLE);
  assign bus.imem_addr = r_req_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];
  assign bus.out_instr = w_head[INSTR_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, directed corner cases, random vs stream model.
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;

  instruction_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();
  instruction_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus_w ();

  instruction_fetch_unit #(
    .ADDR_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instruction_fetch_unit #(
    .ADDR_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)
  ) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } pop_t;

  typedef struct {
    bit          ready;
    bit          redir;
    logic [63:0] rpc;
    bit          chk_addr;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_valid;
    logic [63:0] e_pc;
    bit          chk_w;
    logic [63:0] e_waddr;
  } vec_t;

  int          n_tests;
  int          n_fail;
  int          lat;
  int          mem_wait;
  bit          rand_lat;
  bit          last_req;
  bit          last_ack;
  logic [63:0] last_addr;
  logic [63:0] req_log [$];
  pop_t        pop_log [$];
  vec_t        vecs [10];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_A5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_monitor();
    last_req  = 1'b0;
    last_ack  = 1'b0;
    last_addr = '0;
    mem_wait  = 0;
    req_log.delete();
    pop_log.delete();
    bus.imem_ack   = 1'b0;
    bus_w.imem_ack = 1'b0;
  endtask

  // Called at a falling edge: checks the request hold rule, answers memory, logs pops, advances one cycle.
  task automatic tick();
    if (last_req && !last_ack) begin
      check("hold_req", bus.imem_req, 1'b1);
      check("hold_addr", bus.imem_addr, last_addr);
    end
    if (bus.imem_req) begin
      if (!last_req || last_ack) begin
        req_log.push_back(bus.imem_addr);
        if (rand_lat) lat = $urandom_range(0, 3);
        mem_wait = 0;
      end
      if (mem_wait >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        mem_wait++;
      end
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      mem_wait       = 0;
    end
    last_req  = bus.imem_req;
    last_ack  = bus.imem_ack;
    last_addr = bus.imem_addr;
    if (bus.out_valid && bus.out_ready) pop_log.push_back('{bus.out_pc, bus.out_instr});
    bus_w.imem_ack   = bus_w.imem_req;
    bus_w.imem_rdata = mem_word(bus_w.imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge where reset is released.
  task automatic do_reset();
    reset              = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rand_lat           = 1'b0;
    lat                = 0;
    clear_monitor();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rpc;
    logic [63:0] exp_pc;
    bit          redir;
    bit          found;
    int          n_pop;
    pop_t        p;

    n_tests = 0;
    n_fail  = 0;
    bus.imem_rdata      = '0;
    bus_w.out_ready     = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc   = '0;
    bus_w.imem_rdata    = '0;

    // Zero-wait stream, redirect to 0x203 landing on an ack, and the wrap-around instance.
    vecs[0] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[1] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h0,   1'b0, 64'h0,   1'b1, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[2] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h4,   1'b1, 64'h0,   1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[3] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   1'b1, 64'h4,   1'b1, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'hC,   1'b1, 64'h8,   1'b1, 64'h4};
    vecs[5] = '{1'b1, 1'b1, 64'h203, 1'b1, 1'b1, 64'h10,  1'b1, 64'hC,   1'b0, 64'h0};
    vecs[6] = '{1'b1, 1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0, 64'h0};
    vecs[7] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h200, 1'b0, 64'h0,   1'b0, 64'h0};
    vecs[8] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h204, 1'b1, 64'h200, 1'b0, 64'h0};
    vecs[9] = '{1'b1, 1'b0, 64'h0,   1'b1, 1'b1, 64'h208, 1'b1, 64'h204, 1'b0, 64'h0};

    do_reset();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("v%0d_req", k), bus.imem_req, vecs[k].e_req);
      if (vecs[k].chk_addr) check($sformatf("v%0d_addr", k), bus.imem_addr, vecs[k].e_addr);
      check($sformatf("v%0d_valid", k), bus.out_valid, vecs[k].e_valid);
      check($sformatf("v%0d_pc", k), bus.out_pc, vecs[k].e_valid ? vecs[k].e_pc : 64'h0);
      check($sformatf("v%0d_instr", k), bus.out_instr,
            vecs[k].e_valid ? {32'h0, mem_word(vecs[k].e_pc)} : 64'h0);
      if (vecs[k].chk_w) check($sformatf("v%0d_wrap_addr", k), bus_w.imem_addr, vecs[k].e_waddr);
      bus.out_ready      = vecs[k].ready;
      bus.redirect_valid = vecs[k].redir;
      bus.redirect_pc    = vecs[k].rpc;
      tick();
      bus.redirect_valid = 1'b0;
    end

    // Queue fills with decode stalled, one pop reopens fetch at 16, then a redirect from IDLE.
    do_reset();
    for (int i = 0; i < 20 && !(req_log.size() > 0 && !bus.imem_req); i++) tick();
    check("full_req_low", bus.imem_req, 1'b0);
    check("full_req_count", req_log.size(), 4);
    check("full_head_pc", bus.out_pc, 64'h0);
    check("full_head_instr", bus.out_instr, {32'h0, mem_word(64'h0)});
    tick();
    tick();
    check("full_stays_idle", bus.imem_req, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pop_req_still_low", bus.imem_req, 1'b0);
    check("pop_new_head", bus.out_pc, 64'h4);
    tick();
    check("refill_req", bus.imem_req, 1'b1);
    check("refill_addr", bus.imem_addr, 64'h10);
    tick();
    check("refull_req_low", bus.imem_req, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h300;
    tick();
    bus.redirect_valid = 1'b0;
    check("idle_redir_valid", bus.out_valid, 1'b0);
    check("idle_redir_req", bus.imem_req, 1'b0);
    tick();
    check("idle_redir_req_up", bus.imem_req, 1'b1);
    check("idle_redir_addr", bus.imem_addr, 64'h300);
    check("idle_redir_still_empty", bus.out_valid, 1'b0);

    // 3-cycle memory, redirect one cycle after the request for 8 goes out.
    do_reset();
    lat           = 3;
    bus.out_ready = 1'b1;
    found         = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == 64'h8) found = 1'b1;
      else tick();
    end
    check("lat_req8_seen", found, 1'b1);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    tick();
    bus.redirect_valid = 1'b0;
    check("discard_req", bus.imem_req, 1'b1);
    check("discard_addr", bus.imem_addr, 64'h8);
    check("discard_empty", bus.out_valid, 1'b0);
    req_log.delete();
    pop_log.delete();
    for (int i = 0; i < 30 && req_log.size() < 2; i++) tick();
    check("lat_req_count", req_log.size(), 2);
    check("lat_first_req", (req_log.size() > 0) ? req_log[0] : '1, 64'h100);
    check("lat_second_req", (req_log.size() > 1) ? req_log[1] : '1, 64'h104);
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) tick();
    check("lat_first_pop", (pop_log.size() > 0) ? pop_log[0].pc : '1, 64'h100);

    // Reset while a request is outstanding with two entries queued.
    do_reset();
    tick();
    tick();
    tick();
    check("pre_rst_req", bus.imem_req, 1'b1);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 64'h0);
    check("rst_pc", bus.out_pc, 64'h0);
    clear_monitor();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("resume_req", bus.imem_req, 1'b1);
    check("resume_addr", bus.imem_addr, 64'h0);
    check("resume_valid", bus.out_valid, 1'b0);

    // Random latency, back-pressure and redirects against an in-order instruction stream model.
    do_reset();
    rand_lat = 1'b1;
    exp_pc   = 64'h0;
    n_pop    = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 6);
      redir         = ($urandom_range(0, 39) == 0);
      rpc           = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, rpc[3:0]};
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      tick();
      bus.redirect_valid = 1'b0;
      while (pop_log.size() > 0) begin
        p = pop_log.pop_front();
        check("rnd_pc", p.pc, exp_pc);
        check("rnd_instr", {32'h0, p.instr}, {32'h0, mem_word(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        n_pop++;
      end
      if (redir) begin
        exp_pc = rpc & ~64'h3;
        check("rnd_flush", bus.out_valid, 1'b0);
      end
      if (!bus.out_valid) check("rnd_mask", {bus.out_pc[31:0], bus.out_instr}, 64'h0);
    end
    check("rnd_progress", (n_pop > 300), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
